// File: rtl/memory_4x8.sv
// Small synchronous single-port register-file memory with registered, held read data.
// Reset is asynchronous and active-low and clears every word and both outputs.
module memory_4x8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              wr_acc_s;
  logic              rd_acc_s;

  // Strobe qualification: only a clean 1 is accepted; 0, X or Z leave state untouched.
  always_comb begin
    wr_acc_s = 1'b0;
    rd_acc_s = 1'b0;
    if (wr_en == 1'b1) begin
      wr_acc_s = 1'b1;
    end else begin
      wr_acc_s = 1'b0;
    end
    if (rd_en == 1'b1) begin
      rd_acc_s = 1'b1;
    end else begin
      rd_acc_s = 1'b0;
    end
  end

  // Storage array: cleared on reset, written on an accepted write strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_acc_s) begin
      mem_r[addr] <= wdata;
    end
  end

  // Read port: one-cycle latency, write-first bypass since read and write share addr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata  <= {DATA_W{1'b0}};
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_acc_s;
      if (rd_acc_s) begin
        if (wr_acc_s) begin
          rdata <= wdata;
        end else begin
          rdata <= mem_r[addr];
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_4x8.sv
// Directed self-checking bench for memory_4x8 with hand-computed expected values.
`timescale 1ns/1ps
module tb_memory_4x8;

  logic       clk;
  logic       reset;
  logic [1:0] addr;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rvalid;

  int n_checks;
  int n_fail;

  memory_4x8 #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .wdata  (wdata),
    .rdata  (rdata),
    .rvalid (rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [1:0] a, input logic [7:0] exp);
    @(negedge clk);
    addr  = a;
    wr_en = 1'b0;
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    check_val({tag, "_rdata"}, rdata, exp);
    check_val({tag, "_rvalid"}, {7'd0, rvalid}, 8'h01);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0;
    addr  = 2'd0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wdata = 8'h00;

    // Reset state
    #12;
    check_val("rst_rdata", rdata, 8'h00);
    check_val("rst_rvalid", {7'd0, rvalid}, 8'h00);
    #8;
    reset = 1'b1;

    // Step 1: all words read back zero, rvalid pulses one cycle
    for (int i = 0; i < 4; i++) do_read("s1_rd", i[1:0], 8'h00);
    @(posedge clk); #1;
    check_val("s1_rvalid_drop", {7'd0, rvalid}, 8'h00);

    // Step 2: write then read, data held after rd_en drops
    do_write(2'd1, 8'hAA);
    do_read("s2_rd", 2'd1, 8'hAA);
    @(posedge clk); #1;
    check_val("s2_hold", rdata, 8'hAA);
    check_val("s2_rvalid_drop", {7'd0, rvalid}, 8'h00);

    // Step 3: distinct words, reverse readback
    do_write(2'd0, 8'h11);
    do_write(2'd1, 8'h22);
    do_write(2'd2, 8'h33);
    do_write(2'd3, 8'h44);
    do_read("s3_rd3", 2'd3, 8'h44);
    do_read("s3_rd2", 2'd2, 8'h33);
    do_read("s3_rd1", 2'd1, 8'h22);
    do_read("s3_rd0", 2'd0, 8'h11);

    // Step 4: same-edge write and read, write-first
    @(negedge clk);
    addr  = 2'd2;
    wdata = 8'h5C;
    wr_en = 1'b1;
    rd_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_val("s4_bypass", rdata, 8'h5C);
    check_val("s4_rvalid", {7'd0, rvalid}, 8'h01);
    do_read("s4_reread", 2'd2, 8'h5C);

    // Step 6: enables X/0 with toggling addr/wdata change nothing
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      addr  = i[1:0];
      wdata = 8'hF0 ^ i[7:0];
      wr_en = (i % 2 == 0) ? 1'bx : 1'b0;
      rd_en = (i % 3 == 0) ? 1'bx : 1'b0;
      @(posedge clk); #1;
      check_val("s6_rdata_held", rdata, 8'h5C);
      check_val("s6_rvalid_low", {7'd0, rvalid}, 8'h00);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    do_read("s6_rd0", 2'd0, 8'h11);
    do_read("s6_rd1", 2'd1, 8'h22);
    do_read("s6_rd2", 2'd2, 8'h5C);
    do_read("s6_rd3", 2'd3, 8'h44);

    // Step 5: reset mid-stream aborts in-flight write and clears outputs immediately
    @(negedge clk);
    addr  = 2'd0;
    wdata = 8'hFF;
    wr_en = 1'b1;
    rd_en = 1'b1;
    reset = 1'b0;
    #2;
    check_val("s5_rdata_clr", rdata, 8'h00);
    check_val("s5_rvalid_clr", {7'd0, rvalid}, 8'h00);
    #3;
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1;
    check_val("s5_rdata_in_rst", rdata, 8'h00);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) do_read("s5_rd", i[1:0], 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
